mmi_regbank: RTL and testbench

- Parametrised memory-mapped register bank; successor to the fixed 8-word CPU/CP/COM exchange bank.
- Bridges the CPU MMI bus to hardware clients (CP, communication) through a generic array of registers.
- Each register is either CPU-writable (control) or hardware-owned (status).
- Adds a proper valid/ready FSM, error response, per-register hardware write enables and a write-1-to-clear interrupt register with enable mask and IRQ output.

---
 rtl/mmi_regbank_if.sv | 24 ++
 rtl/mmi_regbank.sv | 154 +++++++++++++++
 tb/tb_mmi_regbank.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/mmi_regbank_if.sv
// MMI bus between the CPU (master) and the register bank (slave).
// The request is held until the slave answers with a one-cycle ready pulse.
interface mmi_regbank_if #(
    parameter int AW = 3,
    parameter int DW = 32
);
    logic              mmi_valid;
    logic [DW/8-1:0]   mmi_wstrb;
    logic [AW-1:0]     i_mmi_addr;
    logic [DW-1:0]     i_mmi_wdata;
    logic              mmi_ready;
    logic              mmi_err;
    logic [DW-1:0]     o_mmi_rdata;

    modport master (
        output mmi_valid, mmi_wstrb, i_mmi_addr, i_mmi_wdata,
        input  mmi_ready, mmi_err, o_mmi_rdata
    );

    modport slave (
        input  mmi_valid, mmi_wstrb, i_mmi_addr, i_mmi_wdata,
        output mmi_ready, mmi_err, o_mmi_rdata
    );
endinterface

// File: rtl/mmi_regbank.sv
// Parametrised memory-mapped register bank between the CPU MMI bus and
// hardware clients. Registers flagged in RO_MASK are hardware-owned status
// words; the rest are CPU control words, one of which is a write-1-to-clear
// interrupt status register gated by an enable register into irq.
module mmi_regbank #(
    parameter int              NREG    = 8,
    parameter int              AW      = 3,
    parameter int              DW      = 32,
    parameter logic [NREG-1:0] RO_MASK = NREG'(8'h07),
    parameter int              IRQ_IDX = NREG - 2,
    parameter int              IEN_IDX = NREG - 1
) (
    input  logic                clk,
    input  logic                rst,
    mmi_regbank_if.slave        bus,
    input  logic [NREG-1:0]     hw_we,
    input  logic [NREG*DW-1:0]  hw_wdata,
    input  logic [DW-1:0]       hw_irq_set,
    output logic [NREG*DW-1:0]  reg_q,
    output logic [NREG-1:0]     cpu_wr_pulse,
    output logic                irq
);

    typedef enum logic {IDLE, RESP} state_t;

    state_t          state_reg;
    logic            ready_reg;
    logic            err_reg;
    logic            irq_reg;
    logic [DW-1:0]   rdata_reg;
    logic [NREG-1:0] pulse_reg;

    logic [DW-1:0]   regs_reg  [NREG];
    logic [DW-1:0]   regs_next [NREG];

    logic [NREG-1:0] sel;
    logic [NREG-1:0] wr_sel;
    logic [DW-1:0]   bmask;
    logic [DW-1:0]   rd_mux;
    logic            accept;
    logic            is_wr;
    logic            addr_ok;
    logic            ro_hit;
    logic            acc_err;

    // hw_we/hw_wdata lanes of CPU-owned registers are deliberately ignored.
    logic            unused_hw;
    assign unused_hw = ^{hw_we, hw_wdata};

    // Expand byte strobes into a bit mask.
    for (genvar gi = 0; gi < DW/8; gi++) begin : g_bmask
        assign bmask[gi*8 +: 8] = {8{bus.mmi_wstrb[gi]}};
    end

    // Flat register view straight from the flops.
    for (genvar gi = 0; gi < NREG; gi++) begin : g_regq
        assign reg_q[gi*DW +: DW] = regs_reg[gi];
    end

    // Address decode and read mux; an out-of-range address selects nothing.
    always_comb begin
        sel    = '0;
        rd_mux = '0;
        for (int i = 0; i < NREG; i++) begin
            sel[i] = (bus.i_mmi_addr == AW'(i));
            if (sel[i]) begin
                rd_mux = rd_mux | regs_reg[i];
            end
        end
    end

    assign addr_ok = |sel;
    assign is_wr   = |bus.mmi_wstrb;
    assign ro_hit  = |(sel & RO_MASK);
    assign acc_err = !addr_ok || (is_wr && ro_hit);
    assign accept  = (state_reg == IDLE) && bus.mmi_valid;
    assign wr_sel  = (accept && is_wr && !acc_err) ? sel : '0;

    // Next register contents: hardware loads for status words, CPU byte
    // writes for control words, and W1C with set-priority for the IRQ word.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            regs_next[i] = regs_reg[i];
            if (RO_MASK[i]) begin
                if (hw_we[i]) begin
                    regs_next[i] = hw_wdata[i*DW +: DW];
                end
            end else if (i == IRQ_IDX) begin
                regs_next[i] = (regs_reg[i] & ~(wr_sel[i] ? (bus.i_mmi_wdata & bmask) : '0))
                             | hw_irq_set;
            end else if (wr_sel[i]) begin
                regs_next[i] = (regs_reg[i] & ~bmask) | (bus.i_mmi_wdata & bmask);
            end
        end
    end

    // Register storage; reset wipes everything including a write in flight.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            if (rst) begin
                regs_reg[i] <= '0;
            end else begin
                regs_reg[i] <= regs_next[i];
            end
        end
    end

    // Bus FSM with registered response, write pulses and interrupt output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            ready_reg <= 1'b0;
            err_reg   <= 1'b0;
            rdata_reg <= '0;
            pulse_reg <= '0;
            irq_reg   <= 1'b0;
        end else begin
            irq_reg <= |(regs_reg[IRQ_IDX] & regs_reg[IEN_IDX]);
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        state_reg <= RESP;
                        ready_reg <= 1'b1;
                        err_reg   <= acc_err;
                        rdata_reg <= rd_mux;
                        pulse_reg <= wr_sel;
                    end else begin
                        ready_reg <= 1'b0;
                        err_reg   <= 1'b0;
                        rdata_reg <= '0;
                        pulse_reg <= '0;
                    end
                end
                RESP: begin
                    state_reg <= IDLE;
                    ready_reg <= 1'b0;
                    err_reg   <= 1'b0;
                    rdata_reg <= '0;
                    pulse_reg <= '0;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.mmi_ready   = ready_reg;
    assign bus.mmi_err     = err_reg;
    assign bus.o_mmi_rdata = rdata_reg;
    assign cpu_wr_pulse    = pulse_reg;
    assign irq             = irq_reg;

endmodule

// File: tb/tb_mmi_regbank.sv
// Randomised bench for mmi_regbank with a cycle-level reference model of the
// register bank written directly from the access rules.
module tb_mmi_regbank;
    localparam int              NREG = 8;
    localparam int              AW   = 4;
    localparam int              DW   = 32;
    localparam int              IRQ  = 6;
    localparam int              IEN  = 7;
    localparam logic [NREG-1:0] RO   = 8'h07;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NREG-1:0]    hw_we;
    logic [NREG*DW-1:0] hw_wdata;
    logic [DW-1:0]      hw_irq_set;
    logic [NREG*DW-1:0] reg_q;
    logic [NREG-1:0]    cpu_wr_pulse;
    logic               irq;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] m_reg [NREG];
    logic [DW-1:0] last_rdata;
    logic          last_err;

    always #5 clk = ~clk;

    mmi_regbank_if #(.AW(AW), .DW(DW)) bus();

    mmi_regbank #(
        .NREG(NREG), .AW(AW), .DW(DW), .RO_MASK(RO), .IRQ_IDX(IRQ), .IEN_IDX(IEN)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .hw_we        (hw_we),
        .hw_wdata     (hw_wdata),
        .hw_irq_set   (hw_irq_set),
        .reg_q        (reg_q),
        .cpu_wr_pulse (cpu_wr_pulse),
        .irq          (irq)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock edge: predict from the current inputs and model state, then
    // compare every observable output. acc marks an accepted request.
    task automatic step(input bit acc);
        logic [DW-1:0]   nxt [NREG];
        logic [DW-1:0]   bm;
        logic [DW-1:0]   exp_rd;
        logic [NREG-1:0] exp_pulse;
        bit              exp_rdy, exp_err, exp_irq;
        int              a;
        a = int'(bus.i_mmi_addr);
        bm = '0;
        for (int b = 0; b < DW/8; b++)
            if (bus.mmi_wstrb[b]) bm[b*8 +: 8] = 8'hFF;
        for (int i = 0; i < NREG; i++) begin
            nxt[i] = m_reg[i];
            if (RO[i] && hw_we[i]) nxt[i] = hw_wdata[i*DW +: DW];
        end
        exp_rdy = acc; exp_err = 1'b0; exp_rd = '0; exp_pulse = '0;
        if (acc) begin
            if (a >= NREG) begin
                exp_err = 1'b1;
            end else begin
                exp_rd = m_reg[a];
                if (bus.mmi_wstrb != 0) begin
                    if (RO[a]) begin
                        exp_err = 1'b1;
                    end else begin
                        exp_pulse[a] = 1'b1;
                        if (a == IRQ) nxt[a] = nxt[a] & ~(bus.i_mmi_wdata & bm);
                        else          nxt[a] = (nxt[a] & ~bm) | (bus.i_mmi_wdata & bm);
                    end
                end
            end
        end
        nxt[IRQ] = nxt[IRQ] | hw_irq_set;
        exp_irq = |(m_reg[IRQ] & m_reg[IEN]);
        if (rst) begin
            for (int i = 0; i < NREG; i++) nxt[i] = '0;
            exp_rdy = 1'b0; exp_err = 1'b0; exp_pulse = '0; exp_irq = 1'b0;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NREG; i++) m_reg[i] = nxt[i];
        check_eq("ready", bus.mmi_ready, exp_rdy);
        if (exp_rdy) begin
            check_eq("err", bus.mmi_err, exp_err);
            check_eq("rdata", bus.o_mmi_rdata, exp_rd);
        end
        check_eq("cpu_wr_pulse", cpu_wr_pulse, exp_pulse);
        check_eq("irq", irq, exp_irq);
        for (int i = 0; i < NREG; i++)
            check_eq($sformatf("reg%0d", i), reg_q[i*DW +: DW], m_reg[i]);
        last_rdata = bus.o_mmi_rdata;
        last_err   = bus.mmi_err;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0);
    endtask

    // Full transaction: accept cycle, then RESP cycle with valid still held.
    task automatic xfer(input int addr, input logic [DW-1:0] wdata, input logic [3:0] wstrb);
        logic [DW-1:0] rd;
        logic          er;
        bus.mmi_valid   = 1'b1;
        bus.i_mmi_addr  = AW'(addr);
        bus.i_mmi_wdata = wdata;
        bus.mmi_wstrb   = wstrb;
        step(1'b1);
        rd = last_rdata;
        er = last_err;
        $display("xfer addr=%0d wstrb=%b wdata=%h rdata=%h err=%b", addr, wstrb, wdata, rd, er);
        hw_we      = '0;
        hw_irq_set = '0;
        step(1'b0);
        last_rdata    = rd;
        last_err      = er;
        bus.mmi_valid = 1'b0;
        bus.mmi_wstrb = '0;
    endtask

    initial begin
        for (int i = 0; i < NREG; i++) m_reg[i] = '0;
        bus.mmi_valid = 1'b0; bus.mmi_wstrb = '0; bus.i_mmi_addr = '0; bus.i_mmi_wdata = '0;
        hw_we = '0; hw_wdata = '0; hw_irq_set = '0;

        // Reset, then read every address including those beyond NREG.
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(1);
        for (int a = 0; a < 16; a++) xfer(a, 32'h0, 4'b0000);

        // Byte-strobed write to a control register.
        xfer(3, 32'hA5A5_1234, 4'b0101);
        xfer(3, 32'h0, 4'b0000);
        check_eq("plan_reg3_rd", last_rdata, 32'h00A5_0034);

        // CPU write to a status register is dropped while hardware loads it.
        hw_we = 8'h01; hw_wdata[0 +: DW] = 32'h0000_00C3;
        xfer(0, 32'hFFFF_FFFF, 4'b1111);
        check_eq("plan_ro_err", last_err, 1'b1);
        check_eq("plan_reg0", reg_q[0 +: DW], 32'h0000_00C3);

        // Read returns the pre-update value when hardware loads in the same cycle.
        hw_we = 8'h02; hw_wdata[DW +: DW] = 32'h11;
        idle(1);
        hw_we = 8'h02; hw_wdata[DW +: DW] = 32'h55;
        xfer(1, 32'h0, 4'b0000);
        check_eq("plan_reg1_old", last_rdata, 32'h11);
        xfer(1, 32'h0, 4'b0000);
        check_eq("plan_reg1_new", last_rdata, 32'h55);

        // Interrupt set, set-beats-clear, and clear.
        xfer(IEN, 32'h1, 4'b1111);
        hw_irq_set = 32'h1;
        idle(1);
        hw_irq_set = '0;
        idle(1);
        check_eq("plan_irq_rise", irq, 1'b1);
        hw_irq_set = 32'h1;
        xfer(IRQ, 32'h1, 4'b1111);
        check_eq("plan_irq_setwins", reg_q[IRQ*DW +: DW], 32'h1);
        xfer(IRQ, 32'h0, 4'b1111);
        check_eq("plan_irq_w0", reg_q[IRQ*DW +: DW], 32'h1);
        xfer(IRQ, 32'h1, 4'b1111);
        check_eq("plan_irq_clr", reg_q[IRQ*DW +: DW], 32'h0);
        check_eq("plan_irq_fall", irq, 1'b0);

        // Randomised traffic with hardware activity and back-to-back requests.
        for (int n = 0; n < 300; n++) begin
            hw_we      = ($urandom_range(0, 3) == 0) ? NREG'($urandom) : '0;
            for (int i = 0; i < NREG; i++) hw_wdata[i*DW +: DW] = $urandom;
            hw_irq_set = ($urandom_range(0, 3) == 0) ? (32'h1 << $urandom_range(0, 31)) : '0;
            if ($urandom_range(0, 4) == 0) begin
                idle(1);
                hw_we = '0; hw_irq_set = '0;
            end else begin
                xfer($urandom_range(0, 15), $urandom,
                     ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom));
            end
        end

        // Reset asserted in the RESP cycle of a write.
        hw_we = '0; hw_irq_set = '0;
        bus.mmi_valid = 1'b1; bus.i_mmi_addr = AW'(4);
        bus.i_mmi_wdata = 32'hDEAD_BEEF; bus.mmi_wstrb = 4'b1111;
        step(1'b1);
        rst = 1'b1;
        step(1'b0);
        check_eq("plan_rst_ready", bus.mmi_ready, 1'b0);
        check_eq("plan_rst_reg4", reg_q[4*DW +: DW], 32'h0);
        rst = 1'b0; bus.mmi_valid = 1'b0; bus.mmi_wstrb = '0;
        idle(2);
        for (int a = 0; a < NREG; a++) xfer(a, 32'h0, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
